// File: rtl/aes_key_sched.sv
// AES key expansion for 128/192/256-bit keys: one word per cycle, with round keys
// delivered through a small valid/ready buffer that back-pressures the expansion.
module aes_key_sched #(
  parameter int MAX_NK        = 8,
  parameter int RK_FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         err,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last
);
  localparam int PW = (RK_FIFO_DEPTH > 1) ? $clog2(RK_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(RK_FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(RK_FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RK_FIFO_DEPTH);
  localparam logic [3:0]    MAX_NK_L = 4'(MAX_NK);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [31:0]   key_w [8];
  logic [31:0]   win   [8];
  logic [5:0]    word_i, last_word;
  logic [2:0]    mod_i;
  logic [3:0]    nk_q, nk_sel;
  logic [7:0]    rcon;
  logic [31:0]   sub_in, sub_out, temp, new_word;
  logic          bad_len, accept, round_done, full, advance, push, pop;
  logic [127:0]  fifo_data [RK_FIFO_DEPTH];
  logic [3:0]    fifo_idx  [RK_FIFO_DEPTH];
  logic          fifo_last [RK_FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y, inv;
    y   = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      y   = gf_mul(y, y);
      inv = gf_mul(inv, y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    nk_sel = 4'd8;
    case (key_len)
      2'd0:    nk_sel = 4'd4;
      2'd1:    nk_sel = 4'd6;
      default: nk_sel = 4'd8;
    endcase
    bad_len = (key_len == 2'd3) || (nk_sel > MAX_NK_L);
    accept  = (state == IDLE) && start && !bad_len;
  end

  // One shared SubWord; RotWord is applied ahead of it only on i mod Nk == 0
  always_comb begin
    sub_in  = (mod_i == 3'd0) ? {win[0][23:0], win[0][31:24]} : win[0];
    sub_out = '0;
    for (int b = 0; b < 4; b++) sub_out[8*b +: 8] = sbox(sub_in[8*b +: 8]);
  end

  // win[0] is w[i-1]; w[i-Nk] sits at win[Nk-1] (Nk=8 wraps to index 7)
  always_comb begin
    temp = win[0];
    if (mod_i == 3'd0)                          temp = sub_out ^ {rcon, 24'h0};
    else if (nk_q == 4'd8 && mod_i == 3'd4)     temp = sub_out;
    if ({2'b00, nk_q} > word_i) new_word = key_w[word_i[2:0]];
    else                        new_word = win[nk_q[2:0] - 3'd1] ^ temp;
  end

  always_comb begin
    round_done = (word_i[1:0] == 2'b11);
    full       = (count == FULL_CNT);
    pop        = rk_valid && rk_ready;
    advance    = (state == RUN) && !(round_done && full && !pop);
    push       = advance && round_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_i    <= '0;
      mod_i     <= '0;
      rcon      <= 8'h01;
      nk_q      <= 4'd4;
      last_word <= '0;
      for (int k = 0; k < 8; k++) begin
        win[k]   <= '0;
        key_w[k] <= '0;
      end
    end else if (accept) begin
      word_i    <= '0;
      mod_i     <= '0;
      rcon      <= 8'h01;
      nk_q      <= nk_sel;
      last_word <= {nk_sel, 2'b00} + 6'd27;
      for (int k = 0; k < 8; k++) begin
        win[k]   <= '0;
        key_w[k] <= (k < MAX_NK) ? key_in[255 - 32*k -: 32] : '0;
      end
    end else if (advance) begin
      win[0] <= new_word;
      for (int k = 1; k < 8; k++) win[k] <= win[k-1];
      word_i <= word_i + 6'd1;
      mod_i  <= (mod_i == nk_q[2:0] - 3'd1) ? 3'd0 : mod_i + 3'd1;
      if (mod_i == 3'd0 && {2'b00, nk_q} <= word_i) rcon <= xtime(rcon);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= {win[2], win[1], win[0], new_word};
      fifo_idx[wr_ptr]  <= word_i[5:2];
      fifo_last[wr_ptr] <= (word_i == last_word);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= (state == IDLE) && start && bad_len;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Leaving DRAIN on the popping edge lets busy fall with the last key
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (advance && word_i == last_word) state_nxt = DRAIN;
      DRAIN:   if (count == '0 || (count == CW'(1) && pop)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    rk_valid = (count != '0);
    rk_data  = '0;
    rk_idx   = '0;
    rk_last  = 1'b0;
    if (rk_valid) begin
      rk_data = fifo_data[rd_ptr];
      rk_idx  = fifo_idx[rd_ptr];
      rk_last = fifo_last[rd_ptr];
    end
  end
endmodule

// File: tb/tb_aes_key_sched.sv
// Scoreboard bench for aes_key_sched: a FIPS-197 reference expansion feeds an expected
// queue that a negedge monitor drains; directed known-answer, stall, error and reset cases.
`timescale 1ns/1ps
module tb_aes_key_sched;
  logic         clk = 1'b0;
  logic         rst, start, busy, err, rk_valid, rk_ready, rk_last;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   idx;
    logic         last;
    int           edge_at;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           edge_cnt = 0;
  int           ready_mode = 0;
  int           seen_cnt = 0;
  logic [127:0] seen_data [16];
  logic [7:0]   sbox_tab [256];
  bit           head_seen = 0;
  bit           held = 0;
  logic [127:0] held_data;
  logic [3:0]   held_idx;
  logic         held_last;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes_key_sched #(.MAX_NK(8), .RK_FIFO_DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_len  (key_len),
    .key_in   (key_in),
    .busy     (busy),
    .err      (err),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_idx   (rk_idx),
    .rk_last  (rk_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // S-box from exp/log tables over generator 3, then the affine transform bit by bit
  task automatic build_sbox();
    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] x, inv, s, c;
    c = 8'h63;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = x;
      lg[x] = i;
      x = x ^ ({x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00));
    end
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sbox_tab[a] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox_tab[v[31:24]], sbox_tab[v[23:16]], sbox_tab[v[15:8]], sbox_tab[v[7:0]]};
  endfunction

  task automatic push_expected(input logic [1:0] len, input logic [255:0] key, input int s, input bit timed);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nk, nr;
    nk = (len == 2'd0) ? 4 : (len == 2'd1) ? 6 : 8;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) w[i] = key[255 - 32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
        end else if (nk == 8 && i % 8 == 4) t = sub_word(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++)
      exp_q.push_back('{data: {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}, idx: 4'(r),
                        last: (r == nr), edge_at: timed ? s + 4*(r+1) : -1});
  endtask

  task automatic applyStimulus(input logic [1:0] len, input logic [255:0] key, input bit exp_idle, input bit timed);
    int s;
    bit exp_err;
    exp_err = exp_idle && (len == 2'd3);
    @(posedge clk); #1;
    start   = 1'b1;
    key_len = len;
    key_in  = key;
    s = edge_cnt + 1;
    if (exp_idle && len != 2'd3) push_expected(len, key, s, timed);
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = ~key;
    @(negedge clk);
    checkOutput("err_pulse", err, exp_err);
    checkOutput("busy_after_start", busy, !exp_err);
    if (exp_err) begin
      @(negedge clk);
      checkOutput("err_one_cycle", err, 1'b0);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", busy, 1'b0);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    rk_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       rk_ready = 1'b1;
        1:       rk_ready = ($urandom_range(0, 3) != 0);
        default: rk_ready = 1'b0;
      endcase
    end
  end

  // Monitor: stability while stalled, first-appearance latency, and in-order key checks
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        head_seen = 0;
        held      = 0;
      end else begin
        if (held) begin
          checkOutput("hold_valid", rk_valid, 1'b1);
          checkOutput("hold_data", rk_data, held_data);
          checkOutput("hold_idx", rk_idx, held_idx);
          checkOutput("hold_last", rk_last, held_last);
        end
        if (rk_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_key: got idx %0d data %h, expected no key", rk_idx, rk_data);
          end else begin
            if (!head_seen && exp_q[0].edge_at >= 0)
              checkOutput("latency_edge", edge_cnt, exp_q[0].edge_at);
            head_seen = 1;
            if (rk_ready) begin
              checkOutput("rk_data", rk_data, exp_q[0].data);
              checkOutput("rk_idx", rk_idx, exp_q[0].idx);
              checkOutput("rk_last", rk_last, exp_q[0].last);
              seen_data[rk_idx] = rk_data;
              seen_cnt++;
              void'(exp_q.pop_front());
              head_seen = 0;
            end
          end
        end
        held      = rk_valid && !rk_ready;
        held_data = rk_data;
        held_idx  = rk_idx;
        held_last = rk_last;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] rkey;
    logic [1:0]   rlen;
    rst     = 1'b1;
    start   = 1'b0;
    key_len = 2'd0;
    key_in  = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_err", err, 1'b0);
    checkOutput("reset_valid", rk_valid, 1'b0);
    checkOutput("reset_data", rk_data, 128'h0);
    checkOutput("reset_idx", rk_idx, 4'h0);
    checkOutput("reset_last", rk_last, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] AES-128 known answer with latency");
    ready_mode = 0;
    seen_cnt   = 0;
    applyStimulus(2'd0, KEY128, 1, 1);
    wait_idle(200);
    checkOutput("kat128_rk0", seen_data[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    checkOutput("kat128_rk10", seen_data[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    checkOutput("kat128_count", seen_cnt, 11);

    $display("[TB] AES-192 known answer");
    seen_cnt = 0;
    applyStimulus(2'd1, KEY192, 1, 1);
    wait_idle(200);
    checkOutput("kat192_rk12", seen_data[12], 128'ha4970a331a78dc09c418c271e3a41d5d);
    checkOutput("kat192_count", seen_cnt, 13);

    $display("[TB] AES-256 known answer");
    seen_cnt = 0;
    applyStimulus(2'd2, KEY256, 1, 1);
    wait_idle(200);
    checkOutput("kat256_rk14", seen_data[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    checkOutput("kat256_count", seen_cnt, 15);

    $display("[TB] consumer stalled for 20 cycles");
    ready_mode = 2;
    seen_cnt   = 0;
    applyStimulus(2'd0, KEY128, 1, 0);
    repeat (20) @(negedge clk);
    checkOutput("stall_valid", rk_valid, 1'b1);
    checkOutput("stall_busy", busy, 1'b1);
    checkOutput("stall_rk0", rk_data, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    checkOutput("stall_idx", rk_idx, 4'd0);
    ready_mode = 0;
    wait_idle(200);
    checkOutput("stall_rk10", seen_data[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    checkOutput("stall_count", seen_cnt, 11);

    $display("[TB] reserved key length");
    applyStimulus(2'd3, KEY256, 1, 0);
    repeat (3) @(negedge clk);
    checkOutput("reject_stays_idle", busy, 1'b0);

    $display("[TB] start while busy");
    seen_cnt = 0;
    applyStimulus(2'd1, KEY192, 1, 1);
    repeat (8) @(negedge clk);
    applyStimulus(2'd3, ~KEY192, 0, 0);
    applyStimulus(2'd0, KEY128, 0, 0);
    wait_idle(200);
    checkOutput("midstart_rk12", seen_data[12], 128'ha4970a331a78dc09c418c271e3a41d5d);
    checkOutput("midstart_count", seen_cnt, 13);

    $display("[TB] reset mid-expansion");
    applyStimulus(2'd2, KEY256, 1, 0);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_busy", busy, 1'b0);
    checkOutput("midreset_err", err, 1'b0);
    checkOutput("midreset_valid", rk_valid, 1'b0);
    checkOutput("midreset_data", rk_data, 128'h0);
    checkOutput("midreset_idx", rk_idx, 4'h0);
    checkOutput("midreset_last", rk_last, 1'b0);
    seen_cnt = 0;
    applyStimulus(2'd0, KEY128, 1, 1);
    wait_idle(200);
    checkOutput("postreset_rk10", seen_data[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("[TB] random keys with random back-pressure");
    ready_mode = 1;
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 8; k++) rkey[32*k +: 32] = $urandom;
      rlen = 2'($urandom_range(0, 2));
      applyStimulus(rlen, rkey, 1, 0);
      wait_idle(600);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
